// File: rtl/imem_boot_loader.sv
// Byte-stream program loader: writes a framed image into instruction memory and releases core reset.
// Optional trailing XOR checksum byte is enabled by defining IMEM_BOOT_CHECKSUM_EN.
module imem_boot_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  reload,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  core_rstn,
    output logic                  done,
    output logic                  error
);

    // One bit wider than the largest legal word count so the oversize check is exact.
    localparam int unsigned CNT_W = 17;

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
`ifdef IMEM_BOOT_CHECKSUM_EN
        S_CSUM,
`endif
        S_RUN,
        S_ERR
    } state_t;

    state_t                  state, state_next;
    logic [15:0]             len, len_next;
    logic [1:0]              bcnt, bcnt_next;
    logic [CNT_W-1:0]        widx, widx_next;
    logic [DATA_WIDTH-1:0]   wsr, wsr_next;
    logic                    ready_next, we_next, rstn_next, done_next, error_next;
    logic [ADDR_WIDTH-1:0]   addr_next;
    logic [DATA_WIDTH-1:0]   wdata_next;
    logic [CNT_W-1:0]        hdr_len;
    logic                    accept;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0]              xsum, xsum_next;
`endif

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state      <= S_LEN_LO;
            len        <= '0;
            bcnt       <= '0;
            widx       <= '0;
            wsr        <= '0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rstn  <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            xsum       <= '0;
`endif
        end else begin
            state      <= state_next;
            len        <= len_next;
            bcnt       <= bcnt_next;
            widx       <= widx_next;
            wsr        <= wsr_next;
            in_ready   <= ready_next;
            imem_we    <= we_next;
            imem_addr  <= addr_next;
            imem_wdata <= wdata_next;
            core_rstn  <= rstn_next;
            done       <= done_next;
            error      <= error_next;
`ifdef IMEM_BOOT_CHECKSUM_EN
            xsum       <= xsum_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        len_next   = len;
        bcnt_next  = bcnt;
        widx_next  = widx;
        wsr_next   = wsr;
        we_next    = 1'b0;
        addr_next  = imem_addr;
        wdata_next = imem_wdata;
        accept     = in_valid && in_ready;
        hdr_len    = {1'b0, in_data, len[7:0]};
`ifdef IMEM_BOOT_CHECKSUM_EN
        xsum_next  = xsum;
        if (accept && state != S_CSUM) begin
            xsum_next = xsum ^ in_data;
        end
`endif

        case (state)
            S_LEN_LO: begin
                if (accept) begin
                    len_next[7:0] = in_data;
                    state_next    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_next[15:8] = in_data;
                    if (hdr_len > CNT_W'(2 ** ADDR_WIDTH)) begin
                        state_next = S_ERR;
                    end else if (hdr_len == '0) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                        state_next = S_CSUM;
`else
                        state_next = S_RUN;
`endif
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    wsr_next[{bcnt, 3'b000} +: 8] = in_data;
                    bcnt_next = bcnt + 2'd1;
                    if (bcnt == 2'd3) begin
                        we_next    = 1'b1;
                        addr_next  = widx[ADDR_WIDTH-1:0];
                        wdata_next = wsr_next;
                        widx_next  = widx + CNT_W'(1);
                        if (widx_next == CNT_W'(len)) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                            state_next = S_CSUM;
`else
                            state_next = S_RUN;
`endif
                        end
                    end
                end
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    state_next = (in_data == xsum) ? S_RUN : S_ERR;
                end
            end
`endif
            S_RUN, S_ERR: begin
                if (reload) begin
                    state_next = S_LEN_LO;
                    len_next   = '0;
                    bcnt_next  = '0;
                    widx_next  = '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
                    xsum_next  = '0;
`endif
                end
            end
            default: state_next = S_LEN_LO;
        endcase

        // Core release waits until the final write strobe has gone out.
        ready_next = (state_next != S_RUN) && (state_next != S_ERR);
        rstn_next  = (state_next == S_RUN) && !we_next;
        done_next  = (state_next == S_RUN) && !we_next;
        error_next = (state_next == S_ERR);
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized self-checking bench for imem_boot_loader against a frame-parsing reference model.
module tb_imem_boot_loader;

    localparam int unsigned AW = 8;

    logic          clock = 1'b0;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          reload;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rstn;
    logic          done;
    logic          error;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]  fr[$];
    logic [39:0] wq[$];
    logic [31:0] expw[$];
    int          exp_n;
    bit          exp_err;
    int          exp_bytes;

    imem_boot_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clock(clock), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .reload(reload), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rstn(core_rstn), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!rst && imem_we) wq.push_back({imem_addr, imem_wdata});
    end

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; reload = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
        wq.delete();
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clock);
        reload = 1'b0;
    endtask

    // Offer the first nb bytes of fr with pv percent valid probability; return on the negedge after the last transfer.
    task automatic send(input int nb, input int pv, output int cycles, output bit to);
        int  i;
        bit  v;
        bit  r;
        i = 0; cycles = 0; to = 1'b0;
        while (i < nb) begin
            @(negedge clock);
            v = ($urandom_range(99) < pv);
            in_valid = v;
            in_data  = v ? fr[i] : 8'($urandom);
            r = in_ready;
            @(posedge clock);
            cycles++;
            if (v && r) i++;
            if (cycles > 5000) begin to = 1'b1; break; end
        end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_status(output bit to);
        int c;
        c = 0;
        while (!(done || error) && c < 50) begin @(negedge clock); c++; end
        to = !(done || error);
        @(negedge clock);
    endtask

    task automatic build_frame(input logic [15:0] hdr, input int nw, input bit spec_words);
        logic [31:0] w;
        logic [7:0]  x;
        fr.delete();
        fr.push_back(hdr[7:0]);
        fr.push_back(hdr[15:8]);
        for (int i = 0; i < nw; i++) begin
            w = spec_words ? ((i == 0) ? 32'h0010_0513 : 32'h0000_006F) : $urandom;
            for (int b = 0; b < 4; b++) fr.push_back(w[8*b +: 8]);
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        x = 8'h00;
        foreach (fr[i]) x = x ^ fr[i];
        fr.push_back(x);
`else
        x = 8'h00;
        if (x != 8'h00) fr.push_back(x);
`endif
    endtask

    // Reference: parse the byte frame into word count, expected writes and final status.
    task automatic model();
        logic [7:0] x;
        exp_n = int'(fr[0]) + 256 * int'(fr[1]);
        exp_err = exp_n > (1 << AW);
        expw.delete();
        exp_bytes = exp_err ? 2 : fr.size();
        if (!exp_err) begin
            for (int i = 0; i < exp_n; i++)
                expw.push_back({fr[2+4*i+3], fr[2+4*i+2], fr[2+4*i+1], fr[2+4*i]});
`ifdef IMEM_BOOT_CHECKSUM_EN
            x = 8'h00;
            for (int i = 0; i < fr.size() - 1; i++) x = x ^ fr[i];
            if (fr[fr.size()-1] != x) exp_err = 1'b1;
`else
            x = 8'h00;
`endif
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; reload = 1'b0; in_data = 8'h00;
        #1;
        n_cmp++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, core_rstn, done, error} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%b we=%b addr=%h wdata=%h rstn=%b done=%b err=%b, need all 0",
                     in_ready, imem_we, imem_addr, imem_wdata, core_rstn, done, error);
        end
        repeat (2) @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (in_ready !== 1'b1 || core_rstn !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got rdy=%b rstn=%b, need rdy=1 rstn=0", in_ready, core_rstn);
        end
        wq.delete();
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit to;
        do_reset();
        build_frame(16'd2, 2, 1'b1);
        send(fr.size(), 100, cyc, to);
        n_cmp++;
        if (to || cyc != fr.size()) begin
            n_fail++;
            $display("FAIL b2b_cycles: got %0d cycles (timeout=%b), need %0d", cyc, to, fr.size());
        end
`ifndef IMEM_BOOT_CHECKSUM_EN
        n_cmp++;
        if (imem_we !== 1'b1 || imem_addr !== 8'd1 || imem_wdata !== 32'h0000_006F || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_last_write: got we=%b addr=%0d data=%h done=%b, need we=1 addr=1 data=0000006f done=0",
                     imem_we, imem_addr, imem_wdata, done);
        end
        @(negedge clock);
`endif
        n_cmp++;
        if (done !== 1'b1 || core_rstn !== 1'b1 || in_ready !== 1'b0 || imem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_run: got done=%b rstn=%b rdy=%b we=%b, need 1 1 0 0", done, core_rstn, in_ready, imem_we);
        end
        @(negedge clock);
        n_cmp++;
        if (wq.size() != 2 || wq[0] !== {8'd0, 32'h0010_0513} || wq[1] !== {8'd1, 32'h0000_006F}) begin
            n_fail++;
            $display("FAIL b2b_writes: got %0d writes first=%h, need 2 writes 0000100513/010000006f",
                     wq.size(), (wq.size() > 0) ? wq[0] : 40'h0);
        end
    endtask

    task automatic test_zero_len();
        int cyc;
        bit to;
        do_reset();
        build_frame(16'd0, 0, 1'b0);
        send(fr.size(), 100, cyc, to);
        n_cmp++;
        if (to || core_rstn !== 1'b1 || done !== 1'b1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_run: got rstn=%b done=%b err=%b timeout=%b, need 1 1 0 0", core_rstn, done, error, to);
        end
        repeat (2) @(negedge clock);
        n_cmp++;
        if (wq.size() != 0) begin
            n_fail++;
            $display("FAIL zero_len_writes: got %0d writes, need 0", wq.size());
        end
    endtask

    task automatic test_len_error();
        int cyc;
        bit to;
        do_reset();
        build_frame(16'h0101, 0, 1'b0);
        send(2, 100, cyc, to);
        n_cmp++;
        if (to || error !== 1'b1 || core_rstn !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL len_error: got err=%b rstn=%b rdy=%b done=%b timeout=%b, need 1 0 0 0 0",
                     error, core_rstn, in_ready, done, to);
        end
        repeat (3) @(negedge clock);
        n_cmp++;
        if (wq.size() != 0 || error !== 1'b1) begin
            n_fail++;
            $display("FAIL len_error_hold: got %0d writes err=%b, need 0 writes err=1", wq.size(), error);
        end
        pulse_reload();
        n_cmp++;
        if (error !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL err_reload: got err=%b rdy=%b, need err=0 rdy=1", error, in_ready);
        end
    endtask

    task automatic test_rst_mid_frame();
        int cyc;
        bit to;
        do_reset();
        build_frame(16'd2, 2, 1'b1);
        send(6, 100, cyc, to);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, core_rstn, done, error} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_values: got rdy=%b we=%b addr=%h wdata=%h rstn=%b done=%b err=%b, need all 0",
                     in_ready, imem_we, imem_addr, imem_wdata, core_rstn, done, error);
        end
        @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
        wq.delete();
        send(fr.size(), 70, cyc, to);
        wait_status(to);
        n_cmp++;
        if (to || done !== 1'b1 || wq.size() != 2 || wq[0] !== {8'd0, 32'h0010_0513} || wq[1] !== {8'd1, 32'h0000_006F}) begin
            n_fail++;
            $display("FAIL rst_mid_resend: got done=%b writes=%0d first=%h, need done=1 2 writes first=0000100513",
                     done, wq.size(), (wq.size() > 0) ? wq[0] : 40'h0);
        end
    endtask

    task automatic test_random_frames();
        int          cyc;
        int          pv;
        int          nw;
        bit          to;
        logic [15:0] hdr;
        do_reset();
        for (int it = 0; it < 9; it++) begin
            pv = $urandom_range(30, 90);
            case (it)
                0:       begin hdr = 16'd2; nw = 2; end
                5:       begin hdr = 16'(257 + $urandom_range(0, 500)); nw = 0; end
                6:       begin hdr = 16'd256; nw = 256; pv = 100; end
                7:       begin hdr = 16'd0; nw = 0; end
                8:       begin hdr = 16'd257; nw = 0; end
                default: begin nw = $urandom_range(1, 6); hdr = 16'(nw); end
            endcase
            build_frame(hdr, nw, it == 0);
            model();
            wq.delete();
            send(exp_bytes, pv, cyc, to);
            n_cmp++;
            if (to) begin
                n_fail++;
                $display("FAIL rand_send[%0d]: stream stalled after %0d cycles, need %0d bytes accepted", it, cyc, exp_bytes);
            end
            wait_status(to);
            n_cmp++;
            if (to || done !== !exp_err || error !== exp_err || core_rstn !== !exp_err) begin
                n_fail++;
                $display("FAIL rand_status[%0d]: got done=%b err=%b rstn=%b, need done=%b err=%b rstn=%b",
                         it, done, error, core_rstn, !exp_err, exp_err, !exp_err);
            end
            n_cmp++;
            if (wq.size() != expw.size()) begin
                n_fail++;
                $display("FAIL rand_count[%0d]: got %0d writes, need %0d", it, wq.size(), expw.size());
            end
            for (int i = 0; i < expw.size() && i < wq.size(); i++) begin
                n_cmp++;
                if (wq[i] !== {8'(i), expw[i]}) begin
                    n_fail++;
                    $display("FAIL rand_write[%0d.%0d]: got %h, need %h", it, i, wq[i], {8'(i), expw[i]});
                end
            end
            pulse_reload();
            n_cmp++;
            if (in_ready !== 1'b1 || done !== 1'b0 || error !== 1'b0 || core_rstn !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_reload[%0d]: got rdy=%b done=%b err=%b rstn=%b, need 1 0 0 0",
                         it, in_ready, done, error, core_rstn);
            end
        end
    endtask

`ifdef IMEM_BOOT_CHECKSUM_EN
    task automatic test_checksum();
        int cyc;
        bit to;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            build_frame(16'd1, 1, 1'b1);
            if (k == 1) fr[fr.size()-1] = fr[fr.size()-1] ^ 8'h01;
            send(fr.size(), 60, cyc, to);
            wait_status(to);
            n_cmp++;
            if (to || done !== (k == 0) || error !== (k == 1) || core_rstn !== (k == 0)) begin
                n_fail++;
                $display("FAIL csum[%0d]: got done=%b err=%b rstn=%b, need done=%b err=%b", k, done, error, core_rstn, k == 0, k == 1);
            end
            n_cmp++;
            if (wq.size() != 1 || wq[0] !== {8'd0, 32'h0010_0513}) begin
                n_fail++;
                $display("FAIL csum_write[%0d]: got %0d writes, need 1 write 0000100513", k, wq.size());
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_zero_len();
        test_len_error();
        test_rst_mid_frame();
        test_random_frames();
`ifdef IMEM_BOOT_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
